// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for edge_event_arbiter.
// Optional feature macro: EDGE_EVENT_ARBITER_SYNC_EN (see edge_event_channel).
package edge_arb_pkg;

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_type_e;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_CH      = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of req searching upward from ptr with wrap. Unused upper
    // request bits are zero, so wrapping at 16 behaves like wrapping at N.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0]        ptr);
        rr_pick_t   r;
        logic [3:0] idx;
        r = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            idx = ptr + 4'(k);
            if (!r.valid && req[idx]) begin
                r.valid = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_event_channel.sv
// One input channel: optional synchronizer, edge detect, one pending rise and
// one pending fall event, last-served type and sticky overflow flag.
// EDGE_EVENT_ARBITER_SYNC_EN adds a 2-flop synchronizer ahead of edge detect.
module edge_event_channel
    import edge_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    input  logic       grant,
    input  logic       grant_rise,
    input  logic       overflow_clr,
    output logic       rise_pend,
    output logic       fall_pend,
    output logic       overflow,
    output edge_type_e last_type
);

    logic s;
    logic prev;
    logic rise;
    logic fall;
    logic gr_rise;
    logic gr_fall;
    logic drop;

`ifdef EDGE_EVENT_ARBITER_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    // Two-stage synchronizer for an input asynchronous to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    assign s = raw_in;
`endif

    // Edge detect and drop decision for this cycle
    always_comb begin
        rise    = s & ~prev;
        fall    = ~s & prev;
        gr_rise = grant & grant_rise;
        gr_fall = grant & ~grant_rise;
        drop    = (rise & rise_pend & ~gr_rise) | (fall & fall_pend & ~gr_fall);
    end

    // Pending bits, overflow and last-served type
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= 1'b0;
            rise_pend <= 1'b0;
            fall_pend <= 1'b0;
            overflow  <= 1'b0;
            last_type <= EDGE_FALL;
        end else begin
            prev <= s;
            if (rise)         rise_pend <= 1'b1;
            else if (gr_rise) rise_pend <= 1'b0;
            if (fall)         fall_pend <= 1'b1;
            else if (gr_fall) fall_pend <= 1'b0;
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
            if (grant) last_type <= grant_rise ? EDGE_RISE : EDGE_FALL;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-to-event converter for N lines sharing one valid/ready event port
// with round-robin arbitration.
// EDGE_EVENT_ARBITER_SYNC_EN enables per-channel input synchronizers.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [CW-1:0] evt_chan,
    output logic          evt_rising,
    output logic [N-1:0]  overflow,
    input  logic          overflow_clr
);

    logic [N-1:0]  rise_pend;
    logic [N-1:0]  fall_pend;
    edge_type_e    last_type [N];
    logic [N-1:0]  req;
    logic [N-1:0]  serve_rise;
    logic [N-1:0]  grant;
    logic          grant_rise;
    logic          advance;
    rr_pick_t      pick;
    logic [CW-1:0] ptr;
    logic [CW-1:0] sel_chan;
    logic [CW-1:0] next_ptr;

    for (genvar g = 0; g < N; g++) begin : g_chan
        edge_event_channel u_chan (
            .clk          (clk),
            .rst          (rst),
            .raw_in       (in[g]),
            .grant        (grant[g]),
            .grant_rise   (grant_rise),
            .overflow_clr (overflow_clr),
            .rise_pend    (rise_pend[g]),
            .fall_pend    (fall_pend[g]),
            .overflow     (overflow[g]),
            .last_type    (last_type[g])
        );
    end

    // Eligibility, type selection and round-robin grant
    always_comb begin
        req        = rise_pend | fall_pend;
        advance    = !evt_valid || evt_ready;
        pick       = rr_pick(MAX_CH'(req), 4'(ptr));
        grant      = '0;
        grant_rise = 1'b0;
        sel_chan   = '0;
        next_ptr   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // With both pending, the type opposite the last served one is older
            serve_rise[i] = rise_pend[i] & (~fall_pend[i] | (last_type[i] == EDGE_FALL));
            if (pick.valid && (pick.idx == 4'(i))) begin
                grant[i]   = advance;
                grant_rise = serve_rise[i];
                sel_chan   = CW'(i);
                next_ptr   = (i == N - 1) ? '0 : CW'(i + 1);
            end
        end
    end

    // Output event register and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid  <= 1'b0;
            evt_chan   <= '0;
            evt_rising <= 1'b0;
            ptr        <= '0;
        end else if (advance) begin
            if (pick.valid) begin
                evt_valid  <= 1'b1;
                evt_chan   <= sel_chan;
                evt_rising <= grant_rise;
                ptr        <= next_ptr;
            end else begin
                evt_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed and randomized checks for edge_event_arbiter (N=4).
module tb_edge_event_arbiter;

    localparam int N = 4;
`ifdef EDGE_EVENT_ARBITER_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] in = '0;
    logic         evt_ready = 1'b0;
    logic         overflow_clr = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_chan;
    logic         evt_rising;
    logic [N-1:0] overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_chan     (evt_chan),
        .evt_rising   (evt_rising),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    function automatic logic [3:0] ev();
        return {evt_valid, evt_chan, evt_rising};
    endfunction

    function automatic logic [3:0] enc(input logic v, input logic [1:0] ch, input logic r);
        return {v, ch, r};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; in = '0; evt_ready = 1'b0; overflow_clr = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b0; in = '0; evt_ready = 1'b1;
        tick(2);
        total++; if (ev() !== enc(1'b0, 2'd0, 1'b0)) begin bad++; $display("FAIL reset_out got=%b want=%b", ev(), enc(1'b0, 2'd0, 1'b0)); end
        total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL reset_ovf got=%b want=0000", overflow); end
        rst = 1'b1;
        tick(2);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL idle_release got=%b want=0", evt_valid); end
        in[2] = 1'b1;
        tick(1 + EXTRA);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", evt_valid); end
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd2, 1'b1)) begin bad++; $display("FAIL lat_event got=%b want=%b", ev(), enc(1'b1, 2'd2, 1'b1)); end
        tick(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL lat_oneshot got=%b want=0", evt_valid); end
        total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL lat_ovf got=%b want=0000", overflow); end
    endtask

    task automatic test_round_robin();
        do_reset();
        evt_ready = 1'b1;
        in = 4'b1011;
        tick(1 + EXTRA);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_early got=%b want=0", evt_valid); end
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd0, 1'b1)) begin bad++; $display("FAIL rr_ch0 got=%b want=%b", ev(), enc(1'b1, 2'd0, 1'b1)); end
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd1, 1'b1)) begin bad++; $display("FAIL rr_ch1 got=%b want=%b", ev(), enc(1'b1, 2'd1, 1'b1)); end
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd3, 1'b1)) begin bad++; $display("FAIL rr_ch3 got=%b want=%b", ev(), enc(1'b1, 2'd3, 1'b1)); end
        tick(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b want=0", evt_valid); end
        // pointer should now be 0: channel 0 served before channel 3
        in = 4'b0010;
        tick(2 + EXTRA);
        total++; if (ev() !== enc(1'b1, 2'd0, 1'b0)) begin bad++; $display("FAIL rr_wrap_ch0 got=%b want=%b", ev(), enc(1'b1, 2'd0, 1'b0)); end
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd3, 1'b0)) begin bad++; $display("FAIL rr_wrap_ch3 got=%b want=%b", ev(), enc(1'b1, 2'd3, 1'b0)); end
        tick(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_wrap_drain got=%b want=0", evt_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        evt_ready = 1'b0;
        in[1] = 1'b1;
        tick(1);
        in[1] = 1'b0;
        tick(1 + EXTRA);
        total++; if (ev() !== enc(1'b1, 2'd1, 1'b1)) begin bad++; $display("FAIL stall_first got=%b want=%b", ev(), enc(1'b1, 2'd1, 1'b1)); end
        tick(3);
        total++; if (ev() !== enc(1'b1, 2'd1, 1'b1)) begin bad++; $display("FAIL stall_hold got=%b want=%b", ev(), enc(1'b1, 2'd1, 1'b1)); end
        evt_ready = 1'b1;
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd1, 1'b0)) begin bad++; $display("FAIL stall_second got=%b want=%b", ev(), enc(1'b1, 2'd1, 1'b0)); end
        tick(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", evt_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        evt_ready = 1'b0;
        in = 4'b0001;
        tick(2 + EXTRA);
        in = 4'b1001; tick(1);
        in = 4'b0001; tick(1);
        in = 4'b1001; tick(1 + EXTRA);
        total++; if (overflow !== 4'b1000) begin bad++; $display("FAIL ovf_set got=%b want=1000", overflow); end
        total++; if (ev() !== enc(1'b1, 2'd0, 1'b1)) begin bad++; $display("FAIL ovf_held got=%b want=%b", ev(), enc(1'b1, 2'd0, 1'b1)); end
        evt_ready = 1'b1;
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd3, 1'b1)) begin bad++; $display("FAIL ovf_ev_rise got=%b want=%b", ev(), enc(1'b1, 2'd3, 1'b1)); end
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd3, 1'b0)) begin bad++; $display("FAIL ovf_ev_fall got=%b want=%b", ev(), enc(1'b1, 2'd3, 1'b0)); end
        tick(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_only_two got=%b want=0", evt_valid); end
        total++; if (overflow !== 4'b1000) begin bad++; $display("FAIL ovf_sticky got=%b want=1000", overflow); end
        overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
        total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_clear got=%b want=0000", overflow); end
        evt_ready = 1'b0;
        in = 4'b1000;
        tick(2 + EXTRA);
        total++; if (ev() !== enc(1'b1, 2'd0, 1'b0)) begin bad++; $display("FAIL ovf2_held got=%b want=%b", ev(), enc(1'b1, 2'd0, 1'b0)); end
        in = 4'b0000; tick(1);
        in = 4'b1000; tick(1);
        in = 4'b0000; tick(EXTRA);
        overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
        total++; if (overflow !== 4'b1000) begin bad++; $display("FAIL ovf_set_wins got=%b want=1000", overflow); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        evt_ready = 1'b0;
        in = 4'b1111;
        tick(2 + EXTRA);
        total++; if (ev() !== enc(1'b1, 2'd0, 1'b1)) begin bad++; $display("FAIL mr_pre got=%b want=%b", ev(), enc(1'b1, 2'd0, 1'b1)); end
        #1;
        in = 4'b0100;
        rst = 1'b0;
        #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mr_async got=%b want=0", evt_valid); end
        tick(1);
        rst = 1'b1;
        evt_ready = 1'b1;
        tick(1 + EXTRA);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mr_early got=%b want=0", evt_valid); end
        tick(1);
        total++; if (ev() !== enc(1'b1, 2'd2, 1'b1)) begin bad++; $display("FAIL mr_held_high got=%b want=%b", ev(), enc(1'b1, 2'd2, 1'b1)); end
        tick(1);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mr_drain got=%b want=0", evt_valid); end
        tick(4);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mr_no_stale got=%b want=0", evt_valid); end
    endtask

    task automatic test_random();
        int edges [N];
        int deliv [N];
        int oerr  [N];
        int c;
        do_reset();
        for (int i = 0; i < N; i++) begin
            edges[i] = 0; deliv[i] = 0; oerr[i] = 0;
        end
        for (int cyc = 0; cyc < 640; cyc++) begin
            if (cyc < 600) begin
                evt_ready = ($urandom_range(3) != 0);
                for (int i = 0; i < N; i++) begin
                    if ((i < 2) ? ($urandom_range(15) == 0) : ($urandom_range(2) == 0)) begin
                        in[i] = ~in[i];
                        edges[i]++;
                    end
                end
            end else begin
                evt_ready = 1'b1;
            end
            if (evt_valid && evt_ready) begin
                c = int'(evt_chan);
                if (evt_rising !== ((deliv[c] % 2) == 0)) oerr[c]++;
                deliv[c]++;
            end
            tick(1);
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rnd_drained got=%b want=0", evt_valid); end
        for (int i = 0; i < N; i++) begin
            if (overflow[i] === 1'b0) begin
                total++; if (deliv[i] !== edges[i]) begin bad++; $display("FAIL rnd_count ch%0d got=%0d want=%0d", i, deliv[i], edges[i]); end
                total++; if (oerr[i] !== 0) begin bad++; $display("FAIL rnd_order ch%0d got=%0d want=0", i, oerr[i]); end
            end else begin
                total++; if (deliv[i] >= edges[i]) begin bad++; $display("FAIL rnd_dropped ch%0d got=%0d want<%0d", i, deliv[i], edges[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
